// File: rtl/cache_types.sv
// Shared types and line geometry for the instruction-side prefetch path.
package cache_types;
    typedef enum logic [1:0] {
        pf_idle_s,
        pf_demand_s,
        pf_prefetch_s
    } pf_state_t;

    localparam int LINE_OFFSET_BITS = 5;
    localparam int LINE_TAG_BITS    = 27;
endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] count_o
);
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/inst_line_prefetcher.sv
// Next-line prefetcher between the icache fill port and burst memory:
// demand fills go to memory, the following line is staged in a one-entry buffer.
module inst_line_prefetcher
    import cache_types::*;
#(
    parameter bit PREFETCH_EN = 1'b1,
    parameter int LINE_BITS   = 256,
    parameter int OFFSET_BITS = LINE_OFFSET_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          icache_addr,
    input  logic                 icache_read,
    output logic [LINE_BITS-1:0] icache_rdata,
    output logic                 icache_resp,
    output logic [31:0]          mem_addr,
    output logic                 mem_read,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_resp,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);
    localparam int TAG_W = 32 - OFFSET_BITS;

    pf_state_t            state_q, state_d;
    logic                 pf_valid_q, pf_valid_d;
    logic [TAG_W-1:0]     pf_tag_q, pf_tag_d;
    logic [TAG_W-1:0]     tgt_q, tgt_d;
    logic [LINE_BITS-1:0] pf_data_q, pf_data_d;
    logic                 hit_inc, miss_inc;
    logic [TAG_W-1:0]     req_tag;
    logic                 hit;
    logic                 unused_offset;

    assign req_tag       = icache_addr[31:OFFSET_BITS];
    assign unused_offset = ^icache_addr[OFFSET_BITS-1:0];
    assign hit           = icache_read && pf_valid_q && (pf_tag_q == req_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= pf_idle_s;
            pf_valid_q <= 1'b0;
            pf_tag_q   <= '0;
            tgt_q      <= '0;
            pf_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pf_valid_q <= pf_valid_d;
            pf_tag_q   <= pf_tag_d;
            tgt_q      <= tgt_d;
            pf_data_q  <= pf_data_d;
        end
    end

    // tgt_q holds the line being fetched; the +1 wraps modulo 2**TAG_W.
    always_comb begin
        state_d    = state_q;
        pf_valid_d = pf_valid_q;
        pf_tag_d   = pf_tag_q;
        tgt_d      = tgt_q;
        pf_data_d  = pf_data_q;
        unique case (state_q)
            pf_idle_s: begin
                if (hit) begin
                    pf_valid_d = 1'b0;
                    if (PREFETCH_EN) begin
                        tgt_d   = pf_tag_q + TAG_W'(1);
                        state_d = pf_prefetch_s;
                    end
                end else if (icache_read) begin
                    pf_valid_d = 1'b0;
                    tgt_d      = req_tag;
                    state_d    = pf_demand_s;
                end
            end
            pf_demand_s: begin
                if (mem_resp) begin
                    if (PREFETCH_EN) begin
                        tgt_d   = tgt_q + TAG_W'(1);
                        state_d = pf_prefetch_s;
                    end else begin
                        state_d = pf_idle_s;
                    end
                end
            end
            pf_prefetch_s: begin
                if (mem_resp) begin
                    pf_data_d  = mem_rdata;
                    pf_tag_d   = tgt_q;
                    pf_valid_d = 1'b1;
                    state_d    = pf_idle_s;
                end
            end
            default: state_d = pf_idle_s;
        endcase
    end

    always_comb begin
        icache_resp  = 1'b0;
        icache_rdata = '0;
        mem_read     = 1'b0;
        mem_addr     = '0;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        unique case (state_q)
            pf_idle_s: begin
                if (hit) begin
                    icache_resp  = 1'b1;
                    icache_rdata = pf_data_q;
                    hit_inc      = 1'b1;
                end else if (icache_read) begin
                    miss_inc = 1'b1;
                end
            end
            pf_demand_s: begin
                mem_read = 1'b1;
                mem_addr = {tgt_q, {OFFSET_BITS{1'b0}}};
                if (mem_resp) begin
                    icache_resp  = 1'b1;
                    icache_rdata = mem_rdata;
                end
            end
            pf_prefetch_s: begin
                mem_read = 1'b1;
                mem_addr = {tgt_q, {OFFSET_BITS{1'b0}}};
            end
            default: ;
        endcase
    end

    sat_counter32 u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (hit_inc),
        .count_o (hit_count)
    );

    sat_counter32 u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (miss_inc),
        .count_o (miss_count)
    );
endmodule

// File: tb/tb_inst_line_prefetcher.sv
// Directed bench for inst_line_prefetcher with and without speculative fetch,
// scoreboarding icache responses and memory request addresses.
module tb_inst_line_prefetcher;
    localparam int MEM_LAT = 4;

    logic         clk, rst;
    logic [31:0]  a_icache_addr, b_icache_addr;
    logic         a_icache_read, b_icache_read;
    logic [255:0] a_icache_rdata, b_icache_rdata;
    logic         a_icache_resp, b_icache_resp;
    logic [31:0]  a_mem_addr, b_mem_addr;
    logic         a_mem_read, b_mem_read;
    logic [255:0] a_mem_rdata, b_mem_rdata;
    logic         a_mem_resp, b_mem_resp;
    logic [31:0]  a_hit, a_miss, b_hit, b_miss;

    int vectors = 0;
    int miscompares = 0;
    int b_reads = 0;
    int inject_req = 0;
    int inject_seen = 0;
    bit a_auto = 1'b1;

    logic [255:0] ic_q[$];
    logic [31:0]  a_mem_q[$];
    logic [31:0]  b_mem_q[$];

    inst_line_prefetcher #(.PREFETCH_EN(1'b1), .LINE_BITS(256), .OFFSET_BITS(5)) dut (
        .clk(clk), .rst(rst),
        .icache_addr(a_icache_addr), .icache_read(a_icache_read),
        .icache_rdata(a_icache_rdata), .icache_resp(a_icache_resp),
        .mem_addr(a_mem_addr), .mem_read(a_mem_read),
        .mem_rdata(a_mem_rdata), .mem_resp(a_mem_resp),
        .hit_count(a_hit), .miss_count(a_miss)
    );

    inst_line_prefetcher #(.PREFETCH_EN(1'b0), .LINE_BITS(256), .OFFSET_BITS(5)) dut_np (
        .clk(clk), .rst(rst),
        .icache_addr(b_icache_addr), .icache_read(b_icache_read),
        .icache_rdata(b_icache_rdata), .icache_resp(b_icache_resp),
        .mem_addr(b_mem_addr), .mem_read(b_mem_read),
        .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp),
        .hit_count(b_hit), .miss_count(b_miss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] data_of(input logic [31:0] a);
        return {4{a ^ 32'h3C5A_0F96, ~a}};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model for the prefetching instance; answers after MEM_LAT cycles of mem_read.
    initial begin
        int cnt;
        logic [31:0] e;
        cnt = 0;
        a_mem_resp = 1'b0;
        a_mem_rdata = '0;
        forever begin
            @(negedge clk);
            a_mem_resp = 1'b0;
            if (inject_req != inject_seen) begin
                inject_seen = inject_req;
                a_mem_resp = 1'b1;
                a_mem_rdata = {8{32'hDEAD_BEEF}};
            end else if (a_mem_read && a_auto) begin
                cnt++;
                if (cnt >= MEM_LAT) begin
                    cnt = 0;
                    a_mem_resp = 1'b1;
                    a_mem_rdata = data_of(a_mem_addr);
                    e = (a_mem_q.size() != 0) ? a_mem_q.pop_front() : 32'hxxxx_xxxx;
                    check("a_mem_addr", {224'b0, a_mem_addr}, {224'b0, e});
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        logic [31:0] e;
        cnt = 0;
        b_mem_resp = 1'b0;
        b_mem_rdata = '0;
        forever begin
            @(negedge clk);
            b_mem_resp = 1'b0;
            if (b_mem_read) begin
                cnt++;
                if (cnt >= MEM_LAT) begin
                    cnt = 0;
                    b_reads++;
                    b_mem_resp = 1'b1;
                    b_mem_rdata = data_of(b_mem_addr);
                    e = (b_mem_q.size() != 0) ? b_mem_q.pop_front() : 32'hxxxx_xxxx;
                    check("b_mem_addr", {224'b0, b_mem_addr}, {224'b0, e});
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic drive(input bit sel, input logic [31:0] addr, input logic rd);
        if (sel) begin
            b_icache_addr = addr;
            b_icache_read = rd;
        end else begin
            a_icache_addr = addr;
            a_icache_read = rd;
        end
    endtask

    task automatic wait_resp(input bit sel, input string tag);
        int n;
        logic [255:0] e;
        n = 0;
        while (!(sel ? b_icache_resp : a_icache_resp) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_resp"}, {255'b0, sel ? b_icache_resp : a_icache_resp}, 256'd1);
        e = (ic_q.size() != 0) ? ic_q.pop_front() : 'x;
        check({tag, "_data"}, sel ? b_icache_rdata : a_icache_rdata, e);
    endtask

    task automatic release_read(input bit sel);
        @(posedge clk);
        #1;
        drive(sel, 32'h0, 1'b0);
    endtask

    task automatic wait_idle(input bit sel, input string tag);
        int n;
        n = 0;
        while ((sel ? b_mem_read : a_mem_read) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_idle"}, {255'b0, sel ? b_mem_read : a_mem_read}, 256'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_read", {255'b0, a_mem_read}, 256'd0);
        check("rst_icache_resp", {255'b0, a_icache_resp}, 256'd0);
        check("rst_mem_addr", {224'b0, a_mem_addr}, 256'd0);
        check("rst_icache_rdata", a_icache_rdata, 256'd0);
        check("rst_counts", {192'b0, a_hit, a_miss}, 256'd0);
        rst = 1'b0;

        // Cold miss at 0x1000, then next-line prefetch of 0x1020.
        @(negedge clk);
        #1;
        ic_q.push_back(data_of(32'h0000_1000));
        a_mem_q.push_back(32'h0000_1000);
        a_mem_q.push_back(32'h0000_1020);
        drive(1'b0, 32'h0000_1000, 1'b1);
        #1;
        check("miss_no_same_cycle_resp", {255'b0, a_icache_resp}, 256'd0);
        check("miss_no_same_cycle_mem", {255'b0, a_mem_read}, 256'd0);
        wait_resp(1'b0, "miss_1000");
        check("miss_count_1", {224'b0, a_miss}, 256'd1);
        release_read(1'b0);
        check("pf_1020_read", {255'b0, a_mem_read}, 256'd1);
        check("pf_1020_addr", {224'b0, a_mem_addr}, {224'b0, 32'h0000_1020});
        wait_idle(1'b0, "pf_1020");

        // Buffer hit at 0x1020 answers in the same cycle and launches 0x1040.
        ic_q.push_back(data_of(32'h0000_1020));
        a_mem_q.push_back(32'h0000_1040);
        drive(1'b0, 32'h0000_1020, 1'b1);
        #1;
        wait_resp(1'b0, "hit_1020");
        release_read(1'b0);
        check("hit_count_1", {224'b0, a_hit}, 256'd1);
        check("pf_1040_addr", {224'b0, a_mem_addr}, {224'b0, 32'h0000_1040});

        // Miss at 0x5000 queued behind the in-flight 0x1040 prefetch.
        ic_q.push_back(data_of(32'h0000_5000));
        a_mem_q.push_back(32'h0000_5000);
        a_mem_q.push_back(32'h0000_5020);
        drive(1'b0, 32'h0000_5000, 1'b1);
        #1;
        check("queued_no_resp", {255'b0, a_icache_resp}, 256'd0);
        wait_resp(1'b0, "miss_5000");
        check("miss_5000_addr", {224'b0, a_mem_addr}, {224'b0, 32'h0000_5000});
        check("miss_5000_buf_clr", {255'b0, dut.pf_valid_q}, 256'd0);
        release_read(1'b0);
        wait_idle(1'b0, "pf_5020");

        // Top-of-memory miss wraps the prefetch to line 0.
        ic_q.push_back(data_of(32'hFFFF_FFE0));
        a_mem_q.push_back(32'hFFFF_FFE0);
        a_mem_q.push_back(32'h0000_0000);
        drive(1'b0, 32'hFFFF_FFE0, 1'b1);
        #1;
        wait_resp(1'b0, "miss_ffe0");
        release_read(1'b0);
        check("wrap_pf_read", {255'b0, a_mem_read}, 256'd1);
        check("wrap_pf_addr", {224'b0, a_mem_addr}, 256'd0);
        wait_idle(1'b0, "pf_0");
        ic_q.push_back(data_of(32'h0000_0000));
        a_mem_q.push_back(32'h0000_0020);
        drive(1'b0, 32'h0000_0004, 1'b1);
        #1;
        wait_resp(1'b0, "hit_0004");
        release_read(1'b0);
        check("hit_count_2", {224'b0, a_hit}, 256'd2);
        check("miss_count_3", {224'b0, a_miss}, 256'd3);
        wait_idle(1'b0, "pf_0020");

        // Asynchronous reset while a demand fetch is outstanding.
        a_auto = 1'b0;
        drive(1'b0, 32'h0000_7000, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("demand_7000_read", {255'b0, a_mem_read}, 256'd1);
        check("demand_7000_addr", {224'b0, a_mem_addr}, {224'b0, 32'h0000_7000});
        rst = 1'b1;
        #1;
        check("arst_mem_read", {255'b0, a_mem_read}, 256'd0);
        check("arst_icache_resp", {255'b0, a_icache_resp}, 256'd0);
        check("arst_pf_valid", {255'b0, dut.pf_valid_q}, 256'd0);
        check("arst_counts", {192'b0, a_hit, a_miss}, 256'd0);
        check("arst_mem_addr", {224'b0, a_mem_addr}, 256'd0);
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        inject_req++;
        @(negedge clk);
        #1;
        check("late_resp_icache", {255'b0, a_icache_resp}, 256'd0);
        check("late_resp_mem_read", {255'b0, a_mem_read}, 256'd0);
        @(negedge clk);
        #1;
        check("late_resp_after", {255'b0, a_mem_read}, 256'd0);
        check("late_resp_counts", {192'b0, a_hit, a_miss}, 256'd0);
        a_auto = 1'b1;

        // Pass-through instance: two sequential misses, no speculative reads.
        ic_q.push_back(data_of(32'h0000_0100));
        b_mem_q.push_back(32'h0000_0100);
        drive(1'b1, 32'h0000_0100, 1'b1);
        #1;
        wait_resp(1'b1, "np_miss_100");
        release_read(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("np_no_spec_read", {255'b0, b_mem_read}, 256'd0);
        end
        ic_q.push_back(data_of(32'h0000_0120));
        b_mem_q.push_back(32'h0000_0120);
        drive(1'b1, 32'h0000_0120, 1'b1);
        #1;
        check("np_120_not_hit", {255'b0, b_icache_resp}, 256'd0);
        wait_resp(1'b1, "np_miss_120");
        release_read(1'b1);
        wait_idle(1'b1, "np_after_120");
        check("np_hit_count", {224'b0, b_hit}, 256'd0);
        check("np_miss_count", {224'b0, b_miss}, 256'd2);
        check("np_mem_reads", 256'(b_reads), 256'd2);

        check("a_mem_q_drained", 256'(a_mem_q.size()), 256'd0);
        check("b_mem_q_drained", 256'(b_mem_q.size()), 256'd0);
        check("ic_q_drained", 256'(ic_q.size()), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
